m3_step_seq: RTL
================

M3_STEP_SEQ -- requirements
Module: m3_step_seq

Interface
REQ-001 Parameter STEP_NUM, default 12, steps per electrical round (2..16).
REQ-002 Parameter LEN_W, default 22, width of slice-length and remain counters.
REQ-003 Parameter MIN_LEN, default 64, shortest slice length (fastest speed), >=2.
REQ-004 Parameter MAX_LEN, default 4000000, longest slice length, >=MIN_LEN.
REQ-005 Parameter PRE_LEN, default 4000000, length of the preamble slice after start, >=2.
REQ-006 Parameter RAMP, default 1024, slice-length change per speed pulse.
REQ-007 Parameter CALC_STEP, default 10, step whose last cycle raises nextCalc_1o; must be <STEP_NUM.
REQ-008 Parameter PWR_MAX, default 15, top power level; PWR_W = clog2(PWR_MAX+1).
REQ-009 clkI  in  1  sole clock; all state updates on rising edge.
REQ-010 nRstI  in  1  reset; synchronous, active-low, sampled on rising clkI.
REQ-011 m3startI  in  1  level; high = run request, low = return to IDLE.
REQ-012 m3forceStopI  in  1  level; high forces FAULT.
REQ-013 m3invRotateI  in  1  level; 1 = reverse step order, sampled at slice boundaries.
REQ-014 m3speedINCi / m3speedDECi  in  1 each  one-cycle pulses; shorten / lengthen the slice.
REQ-015 m3powerINCi / m3powerDECi  in  1 each  one-cycle pulses; raise / lower the power level.
REQ-016 stepO  out  4  current step index; 0 outside RUN.
REQ-017 stepPulseO  out  1  one-cycle pulse on the first cycle of each RUN slice.
REQ-018 roundPulseO  out  1  one-cycle pulse when the step index wraps in either direction.
REQ-019 nextCalc_1o  out  1  high on the last cycle of step CALC_STEP in RUN.
REQ-020 workingO  out  1  high in PRE and RUN.
REQ-021 faultO  out  1  high in FAULT.
REQ-022 curLenO  out  LEN_W  slice length applied at the next slice load.
REQ-023 powerO  out  PWR_W  current power level.

Function
REQ-024 States: IDLE, PRE, RUN, FAULT; remain counts down to 1; a slice boundary is the cycle with remain==1.
REQ-025 IDLE: when m3startI=1 and m3forceStopI=0, go to PRE with remain=PRE_LEN.
REQ-026 PRE: at the boundary, go to RUN with step=0 (forward) or STEP_NUM-1 (reverse), remain=curLen, and stepPulseO=1 on that first RUN cycle.
REQ-027 RUN forward: at a boundary, step=step+1, wrapping STEP_NUM-1 to 0 with roundPulseO=1.
REQ-028 RUN reverse: at a boundary, step=step-1, wrapping 0 to STEP_NUM-1 with roundPulseO=1.
REQ-029 Each RUN boundary reloads remain=curLen; a curLen change mid-slice never alters the current remain.
REQ-030 m3startI=0 in PRE or RUN: go to IDLE on the next edge; stepO=0; remain=PRE_LEN; no pulses.
REQ-031 m3forceStopI=1 in any non-reset state: go to FAULT on the next edge; this has priority over start/stop.
REQ-032 FAULT: exit to IDLE only when m3startI=0 and m3forceStopI=0.
REQ-033 speedINC alone: curLen=max(curLen-RAMP, MIN_LEN); speedDEC alone: curLen=min(curLen+RAMP, MAX_LEN); compute without LEN_W overflow.
REQ-034 speedINC and speedDEC in the same cycle: curLen unchanged; speed pulses are accepted in every state.
REQ-035 powerINC alone: powerO saturates at PWR_MAX; powerDEC alone: powerO saturates at 0; both in the same cycle: no change.
REQ-036 stepPulseO, roundPulseO and nextCalc_1o are registered outputs, each exactly one cycle wide.
REQ-037 A direction change takes effect only at the next boundary.

Reset
REQ-038 nRstI=0 at an edge: state=IDLE, remain=PRE_LEN, curLen=MAX_LEN, powerO=0, stepO=0, and all pulses, workingO and faultO =0.
REQ-039 Reset mid-RUN overrides every other input in that cycle.

Verification (STEP_NUM=12, MIN_LEN=4, MAX_LEN=16, PRE_LEN=8, RAMP=4, CALC_STEP=10)
REQ-040 Start forward, hold: workingO rises 1 cycle after start; first stepPulseO 8 cycles later; stepPulseO then every 16 cycles; roundPulseO on the 11->0 wrap; nextCalc_1o on the last cycle of step 10.
REQ-041 Three speedINC pulses, then one more: curLen goes 16->12->8->4 and stays 4; with speedINC and speedDEC together, curLen holds.
REQ-042 Reverse start: first RUN step=11, then 10, ...; roundPulseO on the 0->11 wrap; toggling m3invRotateI mid-slice changes direction only at the next boundary.
REQ-043 m3forceStopI pulsed in RUN: faultO=1 and workingO=0 next cycle; faultO stays 1 until m3startI=0, then IDLE.
REQ-044 nRstI=0 during RUN step 5 with curLen=8 and powerO=3: next cycle all outputs are at reset values and curLenO=16.
REQ-045 16 powerINC pulses: powerO saturates at 15; then 20 powerDEC pulses: powerO=0.

Source files
------------

// File: rtl/m3_step_seq.sv
// Step sequencer for a multi-phase motor: preamble slice, then fixed-length
// step slices with ramped speed, direction control and a saturating power level.
module m3_step_seq #(
  parameter int STEP_NUM  = 12,
  parameter int LEN_W     = 22,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 4000000,
  parameter int PRE_LEN   = 4000000,
  parameter int RAMP      = 1024,
  parameter int CALC_STEP = 10,
  parameter int PWR_MAX   = 15,
  localparam int PWR_W    = $clog2(PWR_MAX + 1)
) (
  input  logic             clkI,
  input  logic             nRstI,
  input  logic             m3startI,
  input  logic             m3forceStopI,
  input  logic             m3invRotateI,
  input  logic             m3speedINCi,
  input  logic             m3speedDECi,
  input  logic             m3powerINCi,
  input  logic             m3powerDECi,
  output logic [3:0]       stepO,
  output logic             stepPulseO,
  output logic             roundPulseO,
  output logic             nextCalc_1o,
  output logic             workingO,
  output logic             faultO,
  output logic [LEN_W-1:0] curLenO,
  output logic [PWR_W-1:0] powerO
);

  typedef enum logic [1:0] {stIdle, stPre, stRun, stFault} state_t;

  localparam logic [LEN_W-1:0] PreLen   = LEN_W'(PRE_LEN);
  localparam logic [LEN_W-1:0] MinLen   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   MinLenX  = (LEN_W+1)'(MIN_LEN);
  localparam logic [LEN_W:0]   MaxLenX  = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W:0]   RampX    = (LEN_W+1)'(RAMP);
  localparam logic [3:0]       LastStep = 4'(STEP_NUM - 1);
  localparam logic [3:0]       CalcStep = 4'(CALC_STEP);
  localparam logic [PWR_W-1:0] PwrMax   = PWR_W'(PWR_MAX);

  state_t           state, stateNext;
  logic [LEN_W-1:0] remain, remainNext;
  logic [LEN_W-1:0] curLen, curLenNext;
  logic [PWR_W-1:0] power, powerNext;
  logic [3:0]       step, stepNext;
  logic             stepPulse, stepPulseNext;
  logic             roundPulse, roundPulseNext;
  logic             nextCalc, nextCalcNext;

  // Ramp arithmetic runs one bit wider so the clamp compare cannot wrap.
  function automatic logic [LEN_W-1:0] lenFaster(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] wide;
    wide = {1'b0, len};
    if (wide < MinLenX + RampX) return MinLen;
    return LEN_W'(wide - RampX);
  endfunction

  function automatic logic [LEN_W-1:0] lenSlower(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] wide;
    wide = {1'b0, len} + RampX;
    if (wide > MaxLenX) return MaxLen;
    return LEN_W'(wide);
  endfunction

  function automatic logic [PWR_W-1:0] pwrUp(input logic [PWR_W-1:0] p);
    return (p == PwrMax) ? p : p + 1'b1;
  endfunction

  function automatic logic [PWR_W-1:0] pwrDown(input logic [PWR_W-1:0] p);
    return (p == '0) ? p : p - 1'b1;
  endfunction

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      state      <= stIdle;
      remain     <= PreLen;
      curLen     <= MaxLen;
      power      <= '0;
      step       <= '0;
      stepPulse  <= 1'b0;
      roundPulse <= 1'b0;
      nextCalc   <= 1'b0;
    end else begin
      state      <= stateNext;
      remain     <= remainNext;
      curLen     <= curLenNext;
      power      <= powerNext;
      step       <= stepNext;
      stepPulse  <= stepPulseNext;
      roundPulse <= roundPulseNext;
      nextCalc   <= nextCalcNext;
    end
  end

  always_comb begin
    curLenNext = curLen;
    if (m3speedINCi && !m3speedDECi)      curLenNext = lenFaster(curLen);
    else if (m3speedDECi && !m3speedINCi) curLenNext = lenSlower(curLen);
    powerNext = power;
    if (m3powerINCi && !m3powerDECi)      powerNext = pwrUp(power);
    else if (m3powerDECi && !m3powerINCi) powerNext = pwrDown(power);
  end

  always_comb begin
    stateNext      = state;
    remainNext     = remain;
    stepNext       = step;
    stepPulseNext  = 1'b0;
    roundPulseNext = 1'b0;
    nextCalcNext   = 1'b0;
    if (m3forceStopI) begin
      stateNext  = stFault;
      remainNext = PreLen;
      stepNext   = '0;
    end else begin
      unique case (state)
        stIdle: begin
          remainNext = PreLen;
          stepNext   = '0;
          if (m3startI) stateNext = stPre;
        end
        stPre: begin
          if (!m3startI) begin
            stateNext  = stIdle;
            remainNext = PreLen;
            stepNext   = '0;
          end else if (remain == LEN_W'(1)) begin
            stateNext     = stRun;
            remainNext    = curLen;
            stepNext      = m3invRotateI ? LastStep : 4'd0;
            stepPulseNext = 1'b1;
          end else begin
            remainNext = remain - 1'b1;
          end
        end
        stRun: begin
          if (!m3startI) begin
            stateNext  = stIdle;
            remainNext = PreLen;
            stepNext   = '0;
          end else if (remain == LEN_W'(1)) begin
            remainNext    = curLen;
            stepPulseNext = 1'b1;
            if (m3invRotateI) begin
              roundPulseNext = (step == 4'd0);
              stepNext       = (step == 4'd0) ? LastStep : step - 4'd1;
            end else begin
              roundPulseNext = (step == LastStep);
              stepNext       = (step == LastStep) ? 4'd0 : step + 4'd1;
            end
          end else begin
            remainNext = remain - 1'b1;
            // Registered, so raise it one cycle early to land on the last cycle.
            nextCalcNext = (remain == LEN_W'(2)) && (step == CalcStep);
          end
        end
        stFault: begin
          remainNext = PreLen;
          stepNext   = '0;
          if (!m3startI) stateNext = stIdle;
        end
        default: stateNext = stIdle;
      endcase
    end
  end

  assign stepO       = step;
  assign stepPulseO  = stepPulse;
  assign roundPulseO = roundPulse;
  assign nextCalc_1o = nextCalc;
  assign workingO    = (state == stPre) || (state == stRun);
  assign faultO      = (state == stFault);
  assign curLenO     = curLen;
  assign powerO      = power;

endmodule
